// File: rtl/dac_sample_feeder_if.sv
// Write-side handshake between the core and the DAC sample feeder.
// The master drives samples in and the slave (the feeder) returns ready.
interface dac_sample_feeder_if #(
  parameter int DATA_W = 10
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, wr_data, input  wr_ready);
  modport slave  (input  wr_valid, wr_data, output wr_ready);
endinterface

// File: rtl/dac_sample_feeder.sv
// Buffers DAC codes in a small FIFO and paces them onto the DAC at a programmable rate.
// Optional macro FEEDER_SAMPLE_CNT_EN adds a 16-bit popped-sample counter port.
module dac_sample_feeder #(
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  dac_sample_feeder_if.slave            wr,
  input  logic                          start,
  input  logic                          stop,
  input  logic [DIV_W-1:0]              div,
  output logic [DATA_W-1:0]             dac_d,
  output logic                          dac_en,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
`ifdef FEEDER_SAMPLE_CNT_EN
  ,
  output logic [15:0]                   sample_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [LW-1:0]     level;
  logic [DIV_W-1:0]  cnt;
  logic [SW-1:0]     scnt;
  logic              active, tick, empty, push, pop, uf_set, arm;

  // ready looks only at the registered level, so a same-cycle pop never frees a full slot
  assign empty       = (level == '0);
  assign wr.wr_ready = (level < LW'(FIFO_DEPTH));
  assign push        = wr.wr_valid && wr.wr_ready;
  assign active      = (state == RUN) || (state == DRAIN);
  assign tick        = active && (cnt >= div);
  assign pop         = tick && !empty;
  assign fifo_level  = level;

  always_comb begin
    state_nxt = state;
    uf_set    = 1'b0;
    arm       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = SETTLE;
          arm       = 1'b1;
        end
      end
      SETTLE: begin
        if (stop)                               state_nxt = DRAIN;
        else if (scnt == SW'(SETTLE_CYC - 1))   state_nxt = RUN;
      end
      RUN: begin
        uf_set = tick && empty;
        if (stop) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (tick && empty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[wptr] <= wr.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      dac_en    <= 1'b0;
      dac_d     <= '0;
      underflow <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      cnt       <= '0;
      scnt      <= '0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != IDLE);
      dac_en <= (state_nxt != IDLE);
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr  <= rptr + AW'(1);
        dac_d <= mem[rptr];
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      // counter is kept across RUN->DRAIN so the sample cadence is unbroken
      cnt  <= (!active || tick) ? '0 : cnt + DIV_W'(1);
      scnt <= (state == SETTLE) ? scnt + SW'(1) : '0;
      if (arm)         underflow <= 1'b0;
      else if (uf_set) underflow <= 1'b1;
    end
  end

`ifdef FEEDER_SAMPLE_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)   sample_cnt <= '0;
    else if (arm) sample_cnt <= '0;
    else if (pop) sample_cnt <= sample_cnt + 16'd1;
  end
`endif

`ifndef SYNTHESIS
  a_level: assert property (@(posedge clk) disable iff (!reset) level <= LW'(FIFO_DEPTH));
  a_en:    assert property (@(posedge clk) disable iff (!reset) dac_en == busy);
`endif
endmodule

// File: tb/tb_dac_sample_feeder.sv
// Randomized + directed bench for dac_sample_feeder; a queue-based reference model
// predicts every cycle's outputs and a negedge monitor pops and compares them.
module tb_dac_sample_feeder;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 16;
  localparam int SETTLE = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop  = 1'b0;
  logic [DIV_W-1:0]  div   = '0;
  logic [DATA_W-1:0] dac_d;
  logic              dac_en, busy, underflow;
  logic [3:0]        fifo_level;
`ifdef FEEDER_SAMPLE_CNT_EN
  logic [15:0]       sample_cnt;
`endif

  dac_sample_feeder_if #(.DATA_W(DATA_W)) wr_bus ();

  dac_sample_feeder #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W), .SETTLE_CYC(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr_bus),
    .start      (start),
    .stop       (stop),
    .div        (div),
    .dac_d      (dac_d),
    .dac_en     (dac_en),
    .busy       (busy),
    .fifo_level (fifo_level),
    .underflow  (underflow)
`ifdef FEEDER_SAMPLE_CNT_EN
    ,
    .sample_cnt (sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  d;
    logic        en;
    logic        busy;
    logic [3:0]  lvl;
    logic        rdy;
    logic        uf;
    logic [15:0] sc;
  } exp_t;

  typedef enum {M_IDLE, M_SETTLE, M_RUN, M_DRAIN} mst_t;

  // reference model: FIFO as a queue, counters as plain integers
  mst_t        m_st = M_IDLE;
  logic [9:0]  m_q[$];
  int          m_cnt = 0;
  int          m_settle = 0;
  logic [9:0]  m_d = '0;
  bit          m_uf = 1'b0;
  int          m_sc = 0;
  bit          m_room, m_active, m_tick, m_was_empty;
  exp_t        exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_q.delete();
      m_st = M_IDLE; m_cnt = 0; m_settle = 0; m_d = '0; m_uf = 1'b0; m_sc = 0;
    end else begin
      m_was_empty = (m_q.size() == 0);
      m_room      = (m_q.size() < DEPTH);
      m_active    = (m_st == M_RUN) || (m_st == M_DRAIN);
      m_tick      = m_active && (m_cnt >= int'(div));
      if (m_tick && !m_was_empty) begin
        m_d  = m_q.pop_front();
        m_sc = (m_sc + 1) % 65536;
      end else if (m_tick && m_st == M_RUN) begin
        m_uf = 1'b1;
      end
      if (wr_bus.wr_valid && m_room) m_q.push_back(wr_bus.wr_data);
      m_cnt = (!m_active || m_tick) ? 0 : m_cnt + 1;
      case (m_st)
        M_IDLE:   if (start && !stop) begin
                    m_st = M_SETTLE; m_settle = 0; m_uf = 1'b0; m_sc = 0;
                  end
        M_SETTLE: begin
                    m_settle++;
                    if (stop)                  m_st = M_DRAIN;
                    else if (m_settle == SETTLE) m_st = M_RUN;
                  end
        M_RUN:    if (stop) m_st = M_DRAIN;
        M_DRAIN:  if (m_tick && m_was_empty) m_st = M_IDLE;
        default:  m_st = M_IDLE;
      endcase
    end
    exp_q.push_back('{d: m_d, en: (m_st != M_IDLE), busy: (m_st != M_IDLE),
                      lvl: 4'(m_q.size()), rdy: (m_q.size() < DEPTH), uf: m_uf,
                      sc: 16'(m_sc)});
  end

  task automatic chk(string name, int act, int expv);
    if (act != expv) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      chk("dac_d",      int'(dac_d),           int'(e.d));
      chk("dac_en",     int'(dac_en),          int'(e.en));
      chk("busy",       int'(busy),            int'(e.busy));
      chk("fifo_level", int'(fifo_level),      int'(e.lvl));
      chk("wr_ready",   int'(wr_bus.wr_ready), int'(e.rdy));
      chk("underflow",  int'(underflow),       int'(e.uf));
`ifdef FEEDER_SAMPLE_CNT_EN
      chk("sample_cnt", int'(sample_cnt),      int'(e.sc));
`endif
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(logic [9:0] v);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_data  = v;
    cyc();
    wr_bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (busy && n < budget) begin
      cyc();
      n++;
    end
    if (busy) begin
      n_err++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  task automatic wait_dac(logic [9:0] v, int budget);
    int n = 0;
    while (dac_d != v && n < budget) begin
      cyc();
      n++;
    end
    if (dac_d != v) begin
      n_err++;
      $display("FAIL wait_dac: dac_d 0x%0h after %0d cycles, expected 0x%0h", dac_d, budget, v);
    end
  endtask

  initial begin
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_data  = 10'h155;
    cyc(2);
    reset = 1'b1;
    wr_bus.wr_valid = 1'b0;
    cyc(2);

    // streaming at div=9
    div = 16'd9;
    for (int i = 0; i < 6; i++) push_word(10'(10'h3FA + i));
    pulse_start();
    cyc(SETTLE + 6 * 10 + 5);
    pulse_stop();
    wait_idle("stream_idle", 100);

    // fill past full with valid held, then flush fast
    wr_bus.wr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_bus.wr_data = 10'(10'h200 + i);
      cyc();
    end
    wr_bus.wr_valid = 1'b0;
    cyc(2);
    div = 16'd0;
    pulse_start();
    cyc(6);
    pulse_stop();
    wait_idle("full_idle", 50);

    // underflow after two samples
    push_word(10'h100);
    push_word(10'h101);
    div = 16'd3;
    pulse_start();
    cyc(SETTLE + 4 * 6);
    pulse_stop();
    wait_idle("uf_idle", 50);

    // stop on the first RUN cycle
    for (int i = 0; i < 3; i++) push_word(10'(10'h0A0 + i));
    div = 16'd1;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(SETTLE);
    pulse_stop();
    wait_idle("drain_idle", 50);

    // reset in the middle of RUN, then start empty
    div = 16'd9;
    for (int i = 0; i < 5; i++) push_word(10'(10'h3FA + i));
    pulse_start();
    wait_dac(10'h3FC, 200);
    reset = 1'b0; cyc(); reset = 1'b1;
    cyc(2);
    div = 16'd2;
    pulse_start();
    cyc(SETTLE + 10);
    pulse_stop();
    wait_idle("rst_idle", 50);

    // random traffic, occasional resets and live div changes
    for (int i = 0; i < 4000; i++) begin
      wr_bus.wr_valid = ($urandom_range(0, 1) == 1);
      wr_bus.wr_data  = 10'($urandom);
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 49) == 0) div = 16'($urandom_range(0, 6));
      reset = ($urandom_range(0, 499) != 0);
      cyc();
    end
    wr_bus.wr_valid = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    pulse_stop();
    wait_idle("rand_idle", 200);
    cyc(2);

    if (n_vec < 100) begin
      n_err++;
      $display("FAIL vector_count: only %0d cycles checked, expected at least 100", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- Sample-streaming stage directly upstream of the 10-bit analog DAC macro (adacc01_3v3).
- Accepts 10-bit codes from the RVMyth core side through a valid/ready write port and buffers them in a small FIFO.
- Drives the DAC `D` bus and `EN` at a programmable sample rate.
- Sequences `EN` ahead of the first code so the DAC sees stable enable before data changes.

Parameters:
- DATA_W, 10, sample width; equals DAC D width.
- FIFO_DEPTH, 8, FIFO entries; power of two, >= 2.
- DIV_W, 16, width of the sample-rate divider input.
- SETTLE_CYC, 4, cycles `dac_en` is held high before the first sample is issued.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-low.
- wr_valid  in  1  write request from core side.
- wr_data  in  DATA_W  sample code to enqueue.
- wr_ready  out  1  FIFO can accept a write this cycle.
- start  in  1  single-cycle pulse: begin streaming.
- stop  in  1  single-cycle pulse: drain FIFO, then disable.
- div  in  DIV_W  sample period minus one, in clk cycles.
- dac_d  out  DATA_W  code to DAC D bus (registered).
- dac_en  out  1  DAC EN (registered).
- busy  out  1  state != IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underflow  out  1  sticky: FIFO empty at a RUN-state sample tick.

Behaviour:
- Reset: `reset`==0 at a clk edge takes effect that edge.
  - Clears dac_d=0, dac_en=0, busy=0, underflow=0, fifo_level=0, FIFO pointers 0, tick counter 0, state IDLE.
  - Applies in any state; FIFO contents are discarded. Writes during reset are ignored.
- Write port:
  - wr_ready = (fifo_level < FIFO_DEPTH), from registered level.
  - A push occurs when wr_valid && wr_ready; writes are accepted in every state.
  - A push and a pop in the same cycle leave the level unchanged.
  - When full, wr_ready=0 even if a pop occurs that cycle.
- Tick counter:
  - Runs only in RUN and DRAIN; held at 0 in IDLE and SETTLE.
  - tick = (cnt >= div). On tick cnt<=0, else cnt<=cnt+1. Sample period = div+1 cycles; div=0 gives a tick every cycle.
  - div is used live. If div is lowered below cnt, the next cycle ticks.
- States:
  - IDLE: dac_en=0; dac_d holds its last value.
    - start && !stop -> SETTLE; underflow clears on this transition.
    - start && stop together: stay IDLE (stop wins).
  - SETTLE: dac_en=1 from the first SETTLE cycle. After exactly SETTLE_CYC cycles -> RUN.
    - stop in SETTLE -> DRAIN.
  - RUN: on tick:
    - FIFO non-empty: pop; dac_d <= head (visible the cycle after the tick).
    - FIFO empty: dac_d holds; underflow <= 1; dac_en stays 1.
    - First tick occurs div+1 cycles after entering RUN.
    - stop -> DRAIN; cnt is kept.
  - DRAIN: on tick:
    - Non-empty: pop as in RUN.
    - Empty: -> IDLE, dac_en<=0 at that edge. underflow is never set in DRAIN.
    - start in DRAIN is ignored.
- dac_d changes only on a pop edge or reset. It never glitches between samples.
- busy = (state != IDLE), registered alongside state.

Optional Feature:
- Macro: FEEDER_SAMPLE_CNT_EN.
- Defined:
  - Adds output port sample_cnt [15:0]: count of samples popped to dac_d since the last IDLE->SETTLE transition.
  - Cleared on reset and on that transition; wraps 0xFFFF->0x0000; holds in IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wr_valid=1, wr_data=0x155.
  - -> after release: dac_d=0x000, dac_en=0, busy=0, fifo_level=0, wr_ready=1, underflow=0.
- Streaming: push 0x3FA..0x3FF (6 words), div=9, pulse start.
  - -> dac_en=1 the cycle after start.
  - -> RUN after 4 cycles.
  - -> dac_d = 0x3FA,0x3FB,...,0x3FF, each held 10 cycles; fifo_level 6->0.
- Full: with streaming stopped, write 9 consecutive words with wr_valid held.
  - -> wr_ready=0 after the 8th; fifo_level=8; the 9th word is never output.
- Underflow: push 0x100,0x101; div=3; start; no further writes.
  - -> dac_d=0x100 then 0x101, which persists.
  - -> underflow=1 after the third RUN tick; dac_en stays 1; busy=1.
- Drain: push 3 words; div=1; start; pulse stop on the first RUN cycle.
  - -> all 3 words output 2 cycles apart, then dac_en=0 and busy=0 on the next tick; underflow=0.
- Reset mid-RUN: drive reset=0 while dac_d=0x3FC with fifo_level=2.
  - -> next edge: dac_d=0, dac_en=0, fifo_level=0, state IDLE.
  - -> after release, start with an empty FIFO sets underflow at the first tick.
